// File: rtl/gs_serializer_pkg.sv
// gs_serializer_pkg: pixel word layout, color encoding and helpers shared with the GS state machine
package gs_serializer_pkg;
  typedef enum logic [1:0] {COLOR_R = 2'd0, COLOR_G = 2'd1, COLOR_B = 2'd2} color_e;
  localparam int PIXEL_WIDTH = 30;
  localparam int GS_BITS = 10;
  localparam int R_OFF = 20;
  localparam int G_OFF = 10;
  localparam int B_OFF = 0;
  function automatic logic is_onehot4(logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
  function automatic logic pixel_bit(logic [PIXEL_WIDTH-1:0] px, logic [1:0] c, logic [3:0] b);
    logic [4:0] idx;
    idx = (c == COLOR_R ? 5'(R_OFF) : c == COLOR_G ? 5'(G_OFF) : 5'(B_OFF)) + {1'b0, b};
    if (c == 2'd3 || b > 4'(GS_BITS - 1)) return 1'b0;
    return px[idx];
  endfunction
endpackage

// File: rtl/gs_serializer_sclk_gen.sv
// sclk_gen: SCLK divider with one-cycle-ahead rise/fall event strobes; parks low when disabled
module sclk_gen #(
  parameter int SCLK_HALF = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  output logic SCLK,
  output logic rise_evt,
  output logic fall_evt
);
  logic [7:0] cnt;
  logic wrap;
  assign wrap = cnt == 8'(SCLK_HALF - 1);
  assign rise_evt = wrap && !SCLK && en;
  assign fall_evt = wrap && SCLK;
  // a high phase always runs to completion so SCLK never glitches short
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= 8'd0;
      SCLK <= 1'b0;
    end else if (!en && !SCLK) begin
      cnt <= 8'd0;
    end else if (wrap) begin
      cnt <= 8'd0;
      SCLK <= ~SCLK;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/gs_serializer.sv
// gs_serializer: fetches one pixel bit per SCLK period and presents SIN/LAT/row_en_out to the LED driver
module gs_serializer
  import gs_serializer_pkg::*;
#(
  parameter int NB_ANGLES = 128,
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int SCLK_HALF = 4,
  localparam int ANGLE_WIDTH = $clog2(NB_ANGLES),
  localparam int LED_WIDTH = $clog2(NB_LEDS_PER_GROUP)
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic [ANGLE_WIDTH-1:0] angle,
  input  logic [LED_WIDTH-1:0] led,
  input  logic [1:0] color,
  input  logic [3:0] bit_sel,
  input  logic [3:0] row_en,
  input  logic lat_req,
  output logic [ANGLE_WIDTH+2+LED_WIDTH-1:0] ram_addr,
  output logic ram_rd,
  input  logic [PIXEL_WIDTH-1:0] ram_rdata,
  output logic SCLK,
  output logic SIN,
  output logic LAT,
  output logic [3:0] row_en_out
);
  logic fall_evt, unused_rise, p1, p2, lat_c;
  logic [1:0] color_c, row_bin;
  logic [3:0] bit_c, row_c;
  sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk(clk),
    .nrst(nrst),
    .en(en),
    .SCLK(SCLK),
    .rise_evt(unused_rise),
    .fall_evt(fall_evt)
  );
  assign row_bin = {row_en[3] | row_en[2], row_en[3] | row_en[1]};
  // p1/p2 track the read cycle and the data-valid cycle after each fall event
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      {p1, p2, lat_c, color_c, bit_c, row_c} <= '0;
      ram_addr <= '0;
      ram_rd <= 1'b0;
      SIN <= 1'b0;
      LAT <= 1'b0;
      row_en_out <= 4'd0;
    end else begin
      if (fall_evt) begin
        color_c <= color;
        bit_c <= bit_sel;
        row_c <= row_en;
        lat_c <= lat_req;
        ram_addr <= {angle, row_bin, led};
      end
      ram_rd <= fall_evt && is_onehot4(row_en);
      p1 <= fall_evt;
      p2 <= p1;
      if (p2) begin
        SIN <= is_onehot4(row_c) && pixel_bit(ram_rdata, color_c, bit_c);
        LAT <= lat_c;
        row_en_out <= is_onehot4(row_c) ? row_c : 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_gs_serializer.sv
// tb_gs_serializer: randomized bench against an event-level model of the serializer
module tb_gs_serializer;
  localparam int H = 4;
  localparam int P = 2 * H;
  logic clk = 0, nrst = 0, en = 0, lat_req = 0;
  logic [6:0] angle = 0;
  logic [3:0] led = 0, bit_sel = 0, row_en = 0;
  logic [1:0] color = 0;
  logic [29:0] ram_rdata = 0;
  logic [12:0] ram_addr;
  logic ram_rd, SCLK, SIN, LAT;
  logic [3:0] row_en_out;
  logic [29:0] mem [8192];
  int checks = 0, errors = 0;
  bit pend = 0;
  logic [29:0] word = 0;
  always #5 clk = ~clk;
  gs_serializer #(.NB_ANGLES(128), .NB_LEDS_PER_GROUP(16), .SCLK_HALF(H)) dut (
    .clk(clk), .nrst(nrst), .en(en), .angle(angle), .led(led), .color(color),
    .bit_sel(bit_sel), .row_en(row_en), .lat_req(lat_req), .ram_addr(ram_addr),
    .ram_rd(ram_rd), .ram_rdata(ram_rdata), .SCLK(SCLK), .SIN(SIN), .LAT(LAT),
    .row_en_out(row_en_out)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // the frame buffer answers a read strobe with data valid exactly one cycle later
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ram_rdata = pend ? word : 30'($urandom);
    pend = ram_rd;
    word = mem[ram_addr];
  endtask
  function automatic bit onehot(logic [3:0] r);
    return r == 4'b0001 || r == 4'b0010 || r == 4'b0100 || r == 4'b1000;
  endfunction
  function automatic int rowidx(logic [3:0] r);
    return r == 4'b0001 ? 0 : r == 4'b0010 ? 1 : r == 4'b0100 ? 2 : 3;
  endfunction
  task automatic set_directed();
    angle = 7'd3; row_en = 4'b0100; led = 4'd5; color = 2'd0; bit_sel = 4'd9; lat_req = 1'b1;
  endtask
  initial begin
    int k, nf, addr;
    logic [6:0] ca;
    logic [3:0] cl, cb, cr;
    logic [1:0] cc;
    logic clat;
    logic esin, elat;
    logic [3:0] erow;
    logic [29:0] w;
    for (int i = 0; i < 8192; i++) mem[i] = 30'($urandom);
    mem[3 * 64 + 2 * 16 + 5] = 30'h3FF00000;
    {ca, cl, cb, cr, cc, clat, esin, elat, erow} = '0;
    en = 1;
    repeat (3) @(negedge clk);
    check("rst_sclk", SCLK, 0);
    check("rst_sin", SIN, 0);
    check("rst_lat", LAT, 0);
    check("rst_rd", ram_rd, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_row", row_en_out, 0);
    nrst = 1;
    k = 0;
    for (int n = 0; n < P * 30; n++) begin
      step();
      k++;
      check("sclk", SCLK, 32'((k / H) % 2));
      if (k % P == 0) begin
        {ca, cl, cc, cb, cr, clat} = {angle, led, color, bit_sel, row_en, lat_req};
        check("ram_rd", ram_rd, onehot(cr));
        if (onehot(cr)) check("ram_addr", ram_addr, ca * 64 + rowidx(cr) * 16 + cl);
      end else begin
        check("ram_rd_idle", ram_rd, 0);
      end
      if (k % P == 2 && k > P) begin
        addr = ca * 64 + rowidx(cr) * 16 + cl;
        w = mem[addr];
        esin = onehot(cr) && cc < 3 && cb < 10 ? w[(2 - cc) * 10 + cb] : 1'b0;
        elat = clat;
        erow = onehot(cr) ? cr : 4'd0;
      end
      check("sin", SIN, esin);
      check("lat", LAT, elat);
      check("row_out", row_en_out, erow);
      angle = 7'($urandom);
      led = 4'($urandom);
      color = 2'($urandom);
      bit_sel = 4'($urandom_range(0, 11));
      row_en = $urandom_range(0, 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      lat_req = 1'($urandom);
      nf = (k + 1) / P;
      if ((k + 1) % P == 0) begin
        if (nf == 1 || nf == 2) begin
          set_directed();
          color = nf == 1 ? 2'd0 : 2'd1;
        end else if (nf == 3) row_en = 4'b0000;
        else if (nf == 4) row_en = 4'b0011;
      end
    end
    set_directed();
    for (int n = 0; n < P && k % P != H; n++) begin
      step();
      k++;
    end
    check("rise", SCLK, 1);
    en = 0;
    for (int j = 1; j < H; j++) begin
      step();
      check("hi_hold", SCLK, 1);
    end
    for (int j = 0; j < 12; j++) begin
      step();
      check("park", SCLK, 0);
    end
    check("park_sin", SIN, 1);
    check("park_lat", LAT, 1);
    check("park_row", row_en_out, 4'b0100);
    en = 1;
    for (int c = 1; c <= H + 1; c++) begin
      step();
      check("reen_sclk", SCLK, c >= H);
    end
    #2 nrst = 0;
    #1;
    check("arst_sclk", SCLK, 0);
    check("arst_sin", SIN, 0);
    check("arst_lat", LAT, 0);
    check("arst_row", row_en_out, 0);
    check("arst_rd", ram_rd, 0);
    repeat (2) @(negedge clk);
    nrst = 1;
    for (int c = 1; c <= 3 * H; c++) begin
      step();
      check("rel_sclk", SCLK, 32'((c / H) % 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
